// File: rtl/button_debouncer_if.sv
// Interface bundle for button_debouncer: the raw (synchronized, still bouncy)
// inputs and the debounced level plus edge pulses, one bit per button.
interface button_debouncer_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] glitchy_signal;
    logic [WIDTH-1:0] debounced_signal;
    logic [WIDTH-1:0] rising_pulse;
    logic [WIDTH-1:0] falling_pulse;

    // Master drives the raw inputs and observes the debounced results.
    modport master (
        output glitchy_signal,
        input  debounced_signal,
        input  rising_pulse,
        input  falling_pulse
    );

    // Slave is the debouncer itself.
    modport slave (
        input  glitchy_signal,
        output debounced_signal,
        output rising_pulse,
        output falling_pulse
    );
endinterface

// File: rtl/button_debouncer.sv
// Multi-bit button debouncer. A single free-running sample counter produces a
// sample tick every SAMPLE_CNT_MAX cycles. On each tick every bit's saturating
// counter either climbs (input high) or clears (input low). A bit is declared
// pressed once its counter saturates at PULSE_CNT_MAX; release is immediate on
// the first low sample. One-cycle rising/falling pulses mark debounced edges.
module button_debouncer #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int PULSE_CNT_MAX  = 200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_debouncer_if.slave    bus
);
    localparam int CNT_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int SAT_W = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [SAT_W-1:0] SAT_FULL = SAT_W'(PULSE_CNT_MAX);

    logic [CNT_W-1:0] r_sample_cnt;
    logic             w_sample_tick;

    assign w_sample_tick = (r_sample_cnt == CNT_LAST);

    // Shared sample-period counter, wraps to 0 after SAMPLE_CNT_MAX-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_cnt <= '0;
        end else if (w_sample_tick) begin
            r_sample_cnt <= '0;
        end else begin
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            logic [SAT_W-1:0] r_sat;
            logic             r_prev;
            logic             w_deb;

            // Saturating high-sample counter; any low sample clears it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sat <= '0;
                end else if (w_sample_tick) begin
                    if (!bus.glitchy_signal[gi]) begin
                        r_sat <= '0;
                    end else if (r_sat != SAT_FULL) begin
                        r_sat <= r_sat + SAT_W'(1);
                    end
                end
            end

            // Delayed copy of the debounced level for edge detection.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= w_deb;
                end
            end

            assign w_deb                    = (r_sat == SAT_FULL);
            assign bus.debounced_signal[gi] = w_deb;
            assign bus.rising_pulse[gi]     = w_deb & ~r_prev;
            assign bus.falling_pulse[gi]    = ~w_deb & r_prev;
        end
    endgenerate
endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 1: number of independent input bits.
REQ-002 SHALL have parameter SAMPLE_CNT_MAX, default 62500: clock cycles per sample period; legal range is 1 or greater.
REQ-003 SHALL have parameter PULSE_CNT_MAX, default 200: consecutive high samples needed to declare a press; legal range is 1 or greater.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge except reset.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port glitchy_signal, input, WIDTH bits: already synchronized to clk by the upstream 2-FF synchronizer; still bouncy.
REQ-007 SHALL have port debounced_signal, output, WIDTH bits: stable level per bit.
REQ-008 SHALL have port rising_pulse, output, WIDTH bits: one-cycle pulse per debounced 0->1 transition.
REQ-009 SHALL have port falling_pulse, output, WIDTH bits: one-cycle pulse per debounced 1->0 transition.

Function
REQ-010 SHALL contain one shared sample counter, counting 0..SAMPLE_CNT_MAX-1 and wrapping to 0 on every clk edge.
- Width: clog2(SAMPLE_CNT_MAX), minimum 1.
REQ-011 SHALL assert internal sample_tick for exactly one cycle whenever the sample counter equals SAMPLE_CNT_MAX-1.
- With SAMPLE_CNT_MAX=1, sample_tick SHALL be high every cycle.
REQ-012 SHALL keep one saturating counter sat[i] per bit, width clog2(PULSE_CNT_MAX+1).
- sat[i] SHALL update only on edges where sample_tick is high.
REQ-013 On a sample_tick edge with glitchy_signal[i]=1 and sat[i]<PULSE_CNT_MAX, sat[i] SHALL increment by 1.
- With sat[i]=PULSE_CNT_MAX it SHALL hold, with no wrap.
REQ-014 On a sample_tick edge with glitchy_signal[i]=0, sat[i] SHALL clear to 0 regardless of its current value.
REQ-015 Input values in cycles where sample_tick is low SHALL have no effect on any state.
REQ-016 debounced_signal[i] SHALL be 1 if and only if sat[i]==PULSE_CNT_MAX, decoded directly from the registered counter.
- Release is therefore detected on the first low sample (asymmetric by design).
REQ-017 SHALL register prev[i] <= debounced_signal[i] every cycle.
- rising_pulse[i] = debounced_signal[i] AND NOT prev[i].
- falling_pulse[i] = NOT debounced_signal[i] AND prev[i].
- Each pulse SHALL last exactly one cycle.
REQ-018 Latency, with input held high from reset release: debounced_signal[i] SHALL rise at clk edge number SAMPLE_CNT_MAX*PULSE_CNT_MAX after reset release.
- rising_pulse[i] SHALL be high only until the next edge.
REQ-019 With debounced high and input dropping low, debounced_signal[i] SHALL fall at the next sample_tick edge.
- falling_pulse[i] SHALL be high for the following single cycle.
REQ-020 Bits SHALL be fully independent; only the sample counter is shared.
- A simultaneous rise on one bit and fall on another in the same cycle SHALL be legal.

Reset
REQ-021 While rst_n=0, all of the following SHALL be 0 immediately, without waiting for a clk edge:
- sample counter, all sat[i], all prev[i];
- debounced_signal, rising_pulse, falling_pulse.
REQ-022 Reset asserted mid-count or while debounced is high SHALL discard all progress and SHALL NOT produce any pulse.
- After release, the full REQ-018 latency applies again.
REQ-023 The first counting edge after rst_n deasserts SHALL advance the sample counter from 0 to 1.

Verification (SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3 unless stated)
REQ-024 Steady press:
- Stimulus: input=1 from reset release.
- Response: debounced 0 through edge 11, 1 at edge 12; rising_pulse high for exactly the cycle between edges 12 and 13; falling_pulse never high.
REQ-025 Bounce rejection:
- Stimulus: input=1 at sample ticks 1 and 2, 0 at tick 3, 1 from tick 4 onward.
- Response: sat returns to 0 at tick 3; debounced rises only at tick 6 (edge 24); exactly one rising_pulse.
REQ-026 Release:
- Stimulus: after debounced=1, drop input to 0 between ticks.
- Response: debounced falls at the next tick edge; falling_pulse high for one cycle; sat=0.
REQ-027 Inter-tick glitches:
- Stimulus: input high only in cycles where sample_tick=0, for 100 cycles.
- Response: sat stays 0; all outputs stay 0.
REQ-028 Asynchronous reset:
- Stimulus: drive rst_n low between clk edges while debounced=1 and sat=3.
- Response: all outputs 0 before the next clk edge; no falling_pulse; after release, debounced rises again only at edge 12.
REQ-029 WIDTH=2, SAMPLE_CNT_MAX=1, PULSE_CNT_MAX=2:
- Stimulus: bit0 held 1; bit1 toggling every cycle.
- Response: bit0 debounced at edge 2; bit1 never debounced; no cross-bit interaction.
